round_timer: RTL and testbench



---
 rtl/round_timer_pkg.sv | 19 +
 rtl/round_timer_bin5_to_bcd.sv | 25 ++
 rtl/round_timer.sv | 122 ++++++++++++
 tb/tb_round_timer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_timer_pkg.sv
// Shared game definitions: round-timer state encoding and seconds arithmetic helpers.
package round_timer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam int unsigned SecW = 5;
  localparam logic [SecW-1:0] SecMax = 5'd31;

  // Clamp a one-bit-wider intermediate back into the seconds range.
  function automatic logic [SecW-1:0] sat_sec(input logic [SecW:0] v);
    return (v > {1'b0, SecMax}) ? SecMax : v[SecW-1:0];
  endfunction

endpackage

// File: rtl/round_timer_bin5_to_bcd.sv
// Combinational 5-bit binary to two-digit BCD; the caller registers the result.
module bin5_to_bcd
  import round_timer_pkg::*;
(
  input  logic [SecW-1:0] bin_i,
  output logic [3:0]      tens_o,
  output logic [3:0]      ones_o
);

  always_comb begin
    tens_o = 4'd0;
    ones_o = bin_i[3:0];
    if (bin_i >= SecW'(30)) begin
      tens_o = 4'd3;
      ones_o = 4'(bin_i - SecW'(30));
    end else if (bin_i >= SecW'(20)) begin
      tens_o = 4'd2;
      ones_o = 4'(bin_i - SecW'(20));
    end else if (bin_i >= SecW'(10)) begin
      tens_o = 4'd1;
      ones_o = 4'(bin_i - SecW'(10));
    end
  end

endmodule

// File: rtl/round_timer.sv
// Per-round countdown timer: one-second prescaler, pause/bonus/abort control, BCD display.
module round_timer
  import round_timer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100000000,
  parameter int unsigned WARN_SEC    = 3,
  parameter int unsigned BONUS_SEC   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SecW-1:0] timer_i,
  input  logic            start_i,
  input  logic            pause_i,
  input  logic            abort_i,
  input  logic            add_sec_i,
  output logic [SecW-1:0] remaining_o,
  output logic [3:0]      bcd_tens_o,
  output logic [3:0]      bcd_ones_o,
  output logic            running_o,
  output logic            warn_o,
  output logic            expired_o
);

  localparam int unsigned PresW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned SumW  = SecW + 1;
  localparam logic [PresW-1:0] TickLast = PresW'(TICK_CYCLES - 1);
  localparam logic [SumW-1:0]  Bonus    = SumW'(BONUS_SEC);

  state_e           state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic [SecW-1:0]  rem_q, rem_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic             running_q, running_d;
  logic             warn_q, warn_d;
  logic             expired_q, expired_d;
  logic             tick;
  logic [SumW-1:0]  sum;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    rem_d     = rem_q;
    expired_d = 1'b0;
    tick      = 1'b0;
    sum       = '0;
    if (abort_i) begin
      state_d = StIdle;
      rem_d   = '0;
      presc_d = '0;
    end else if (start_i) begin
      presc_d = '0;
      if (timer_i != '0) begin
        state_d = StRun;
        rem_d   = timer_i;
      end else begin
        state_d   = StExpired;
        rem_d     = '0;
        expired_d = 1'b1;
      end
    end else if (state_q == StRun || state_q == StPause) begin
      // The prescaler advances on every cycle pause is low, so a pause costs exactly its length.
      state_d = pause_i ? StPause : StRun;
      if (!pause_i) begin
        if (presc_q == TickLast) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      sum   = {1'b0, rem_q} + (add_sec_i ? Bonus : '0) - {{SecW{1'b0}}, tick};
      rem_d = sat_sec(sum);
      if (tick && sum == '0) begin
        state_d   = StExpired;
        presc_d   = '0;
        expired_d = 1'b1;
      end
    end
  end

  always_comb begin
    running_d = (state_d == StRun);
    warn_d    = (state_d == StRun || state_d == StPause) && (rem_d != '0) &&
                (32'(rem_d) <= WARN_SEC);
  end

  bin5_to_bcd u_bcd (
    .bin_i  (rem_d),
    .tens_o (tens_d),
    .ones_o (ones_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      rem_q     <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      running_q <= 1'b0;
      warn_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      rem_q     <= rem_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= running_d;
      warn_q    <= warn_d;
      expired_q <= expired_d;
    end
  end

  assign remaining_o = rem_q;
  assign bcd_tens_o  = tens_q;
  assign bcd_ones_o  = ones_q;
  assign running_o   = running_q;
  assign warn_o      = warn_q;
  assign expired_o   = expired_q;

endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer: directed scenarios plus randomized traffic vs a model.
module tb_round_timer;

  localparam int Tick  = 4;
  localparam int Warn  = 3;
  localparam int Bonus = 2;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;
  localparam int MExp   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] timer_i = '0;
  logic       start_i = 1'b0;
  logic       pause_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       add_sec_i = 1'b0;
  logic [4:0] remaining_o;
  logic [3:0] bcd_tens_o;
  logic [3:0] bcd_ones_o;
  logic       running_o;
  logic       warn_o;
  logic       expired_o;

  round_timer #(
    .TICK_CYCLES (Tick),
    .WARN_SEC    (Warn),
    .BONUS_SEC   (Bonus)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .timer_i     (timer_i),
    .start_i     (start_i),
    .pause_i     (pause_i),
    .abort_i     (abort_i),
    .add_sec_i   (add_sec_i),
    .remaining_o (remaining_o),
    .bcd_tens_o  (bcd_tens_o),
    .bcd_ones_o  (bcd_ones_o),
    .running_o   (running_o),
    .warn_o      (warn_o),
    .expired_o   (expired_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_expired = 0;
  int last_exp_cyc = -1;

  // Behavioural model: mode, seconds left, and position within the current second.
  int m_mode = MIdle;
  int m_rem = 0;
  int m_phase = 0;
  bit m_exp = 1'b0;
  bit m_tick;
  int m_r;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = MIdle;
      m_rem   = 0;
      m_phase = 0;
      m_exp   = 1'b0;
    end else begin
      m_exp = 1'b0;
      if (abort_i) begin
        m_mode  = MIdle;
        m_rem   = 0;
        m_phase = 0;
      end else if (start_i) begin
        m_phase = 0;
        m_rem   = int'(timer_i);
        if (timer_i == 0) begin
          m_mode = MExp;
          m_exp  = 1'b1;
        end else begin
          m_mode = MRun;
        end
      end else if (m_mode == MRun || m_mode == MPause) begin
        m_tick = 1'b0;
        if (!pause_i) begin
          m_phase = (m_phase + 1) % Tick;
          m_tick  = (m_phase == 0);
        end
        m_r = m_rem + (add_sec_i ? Bonus : 0) - (m_tick ? 1 : 0);
        if (m_r > 31) m_r = 31;
        m_rem  = m_r;
        m_mode = pause_i ? MPause : MRun;
        if (m_tick && m_r == 0) begin
          m_mode  = MExp;
          m_phase = 0;
          m_exp   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("remaining", int'(remaining_o), m_rem);
      chk("bcd_tens", int'(bcd_tens_o), m_rem / 10);
      chk("bcd_ones", int'(bcd_ones_o), m_rem % 10);
      chk("running", int'(running_o), (m_mode == MRun) ? 1 : 0);
      chk("warn", int'(warn_o),
          ((m_mode == MRun || m_mode == MPause) && m_rem > 0 && m_rem <= Warn) ? 1 : 0);
      chk("expired", int'(expired_o), int'(m_exp));
      if (expired_o) begin
        n_expired++;
        last_exp_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int t);
    timer_i = 5'(t);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic do_pulse_add();
    add_sec_i = 1'b1;
    step(1);
    add_sec_i = 1'b0;
  endtask

  int c0;
  int n0;

  initial begin
    // Reset state
    step(3);
    chk("rst_remaining", int'(remaining_o), 0);
    chk("rst_outputs", int'({bcd_tens_o, bcd_ones_o, running_o, warn_o, expired_o}), 0);
    rst_n = 1'b1;
    step(2);

    // timer = 10: load, 4-cycle seconds, single expiry 40 cycles after start
    n0 = n_expired;
    do_start(10);
    c0 = cyc;
    chk("s1_load", int'(remaining_o), 10);
    chk("s1_bcd_10", int'({bcd_tens_o, bcd_ones_o}), 8'h10);
    chk("s1_running", int'(running_o), 1);
    step(3);
    chk("s1_hold", int'(remaining_o), 10);
    step(1);
    chk("s1_first_dec", int'(remaining_o), 9);
    chk("s1_bcd_09", int'({bcd_tens_o, bcd_ones_o}), 8'h09);
    step(36);
    chk("s1_expired", int'(expired_o), 1);
    chk("s1_zero", int'(remaining_o), 0);
    step(1);
    chk("s1_pulse_end", int'(expired_o), 0);
    chk("s1_exp_time", last_exp_cyc - c0, 40);
    chk("s1_exp_count", n_expired - n0, 1);
    step(2);

    // timer = 14 with a 10-cycle pause mid-second
    do_start(14);
    step(2);
    pause_i = 1'b1;
    step(3);
    chk("s2_paused_running", int'(running_o), 0);
    chk("s2_paused_rem", int'(remaining_o), 14);
    step(7);
    pause_i = 1'b0;
    step(53);
    chk("s2_not_yet", int'(expired_o), 0);
    step(1);
    chk("s2_expired", int'(expired_o), 1);
    step(2);

    // timer = 6: warn rises entering 3, falls on the expiry edge
    n0 = n_expired;
    do_start(6);
    step(11);
    chk("s3_rem4", int'(remaining_o), 4);
    chk("s3_warn_low", int'(warn_o), 0);
    step(1);
    chk("s3_rem3", int'(remaining_o), 3);
    chk("s3_warn_rise", int'(warn_o), 1);
    step(12);
    chk("s3_expired", int'(expired_o), 1);
    chk("s3_warn_fall", int'(warn_o), 0);
    step(2);
    chk("s3_exp_count", n_expired - n0, 1);

    // timer = 30: saturating bonus, bonus coinciding with the last tick
    do_start(30);
    do_pulse_add();
    chk("s4_sat1", int'(remaining_o), 31);
    do_pulse_add();
    chk("s4_sat2", int'(remaining_o), 31);
    step(121);
    chk("s4_rem1", int'(remaining_o), 1);
    n0 = n_expired;
    do_pulse_add();
    chk("s4_bonus_tick", int'(remaining_o), 2);
    chk("s4_no_expiry", int'(expired_o), 0);
    step(8);
    chk("s4_late_expiry", int'(expired_o), 1);
    step(2);

    // abort at remaining = 5
    do_start(9);
    step(16);
    chk("s5_rem5", int'(remaining_o), 5);
    n0 = n_expired;
    abort_i = 1'b1;
    step(1);
    abort_i = 1'b0;
    chk("s5_abort_rem", int'(remaining_o), 0);
    chk("s5_abort_run", int'(running_o), 0);
    step(20);
    chk("s5_no_expired", n_expired - n0, 0);

    // asynchronous reset mid-round
    do_start(20);
    step(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_rem", int'(remaining_o), 0);
    chk("s6_async_run", int'(running_o), 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // start with timer = 0
    do_start(0);
    chk("s7_zero_expired", int'(expired_o), 1);
    chk("s7_zero_rem", int'(remaining_o), 0);
    step(1);
    chk("s7_zero_pulse_end", int'(expired_o), 0);

    // restart during RUN clears the prescaler
    do_start(20);
    step(6);
    chk("s8_rem19", int'(remaining_o), 19);
    do_start(12);
    chk("s8_reload", int'(remaining_o), 12);
    step(3);
    chk("s8_hold", int'(remaining_o), 12);
    step(1);
    chk("s8_dec", int'(remaining_o), 11);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start_i   = ($urandom_range(0, 39) == 0);
      timer_i   = 5'($urandom_range(0, 31));
      abort_i   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) pause_i = ~pause_i;
      add_sec_i = !pause_i && ($urandom_range(0, 14) == 0);
      step(1);
    end
    start_i   = 1'b0;
    abort_i   = 1'b0;
    pause_i   = 1'b0;
    add_sec_i = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
